// File: rtl/reg_file_sb_pkg.sv
// reg_file_sb_pkg: shared widths and types for the scoreboarded register file.
package reg_file_sb_pkg;

    localparam int unsigned REG_W        = 8;
    localparam int unsigned REG_D        = 4;
    localparam bit          REG_ZERO_REG = 1'b0;

    typedef logic [REG_D-1:0] reg_addr_t;
    typedef logic [REG_W-1:0] reg_data_t;

endpackage

// File: rtl/reg_file_sb_scoreboard.sv
// reg_scoreboard: one busy bit per register, tracking loads that have not
// yet returned. Also tracks the number of outstanding loads and a sticky
// error flag for returns that have no matching outstanding load.
module reg_scoreboard
    import reg_file_sb_pkg::*;
#(
    parameter int unsigned D        = REG_D,
    parameter bit          ZERO_REG = REG_ZERO_REG
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ld_issue,
    input  logic [D-1:0]      ld_addr,
    input  logic              ld_ret_valid,
    input  logic [D-1:0]      ld_ret_addr,
    output logic [(1<<D)-1:0] busy,
    output logic              ld_issue_ready,
    output logic              ret_accept,
    output logic [D:0]        pending_cnt,
    output logic              sb_err
);

    logic [(1<<D)-1:0] sb;
    logic              iss_zero;
    logic              ret_zero;
    logic              iss_ok;
    logic              ret_err;

    assign busy           = sb;
    assign ld_issue_ready = ~sb[ld_addr];

    // Classify this cycle's issue and return requests against the current bits.
    // An issue to a busy register is still taken when that register's load
    // returns on the same edge, so the bit stays set and the count is unchanged.
    always_comb begin
        iss_zero   = ZERO_REG && (ld_addr == '0);
        ret_zero   = ZERO_REG && (ld_ret_addr == '0);
        ret_accept = ld_ret_valid && sb[ld_ret_addr];
        ret_err    = ld_ret_valid && !sb[ld_ret_addr] && !ret_zero;
        iss_ok     = ld_issue && !iss_zero &&
                     (!sb[ld_addr] || (ret_accept && (ld_ret_addr == ld_addr)));
    end

    // Scoreboard bits, outstanding-load count and sticky error flag.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sb          <= '0;
            pending_cnt <= '0;
            sb_err      <= 1'b0;
        end else begin
            if (ret_accept) sb[ld_ret_addr] <= 1'b0;
            if (iss_ok)     sb[ld_addr]     <= 1'b1;
            pending_cnt <= pending_cnt + {{D{1'b0}}, iss_ok} - {{D{1'b0}}, ret_accept};
            if (ret_err) sb_err <= 1'b1;
        end
    end

endmodule

// File: rtl/reg_file_sb.sv
// reg_file_sb: 2^D x W register file with two combinational read ports, an
// ALU write port, a load-return write port and a per-register load scoreboard.
// Build option: define REGFILE_BYPASS_EN to forward same-cycle writes to reads.
module reg_file_sb
    import reg_file_sb_pkg::*;
#(
    parameter int unsigned W        = REG_W,
    parameter int unsigned D        = REG_D,
    parameter bit          ZERO_REG = REG_ZERO_REG
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [D-1:0] raddrA,
    input  logic [D-1:0] raddrB,
    output logic [W-1:0] data_outA,
    output logic [W-1:0] data_outB,
    output logic         busyA,
    output logic         busyB,
    input  logic         wr_en,
    input  logic [D-1:0] waddr,
    input  logic [W-1:0] wdata,
    input  logic         ld_issue,
    input  logic [D-1:0] ld_addr,
    output logic         ld_issue_ready,
    input  logic         ld_ret_valid,
    input  logic [D-1:0] ld_ret_addr,
    input  logic [W-1:0] ld_ret_data,
    output logic [D:0]   pending_cnt,
    output logic         sb_err
);

    localparam int unsigned DEPTH = 1 << D;

    logic [W-1:0]     regs [DEPTH];
    logic [DEPTH-1:0] busy;
    logic             ret_accept;
    logic             wr_ok;

    reg_scoreboard #(
        .D        (D),
        .ZERO_REG (ZERO_REG)
    ) u_sb (
        .clk            (clk),
        .reset          (reset),
        .ld_issue       (ld_issue),
        .ld_addr        (ld_addr),
        .ld_ret_valid   (ld_ret_valid),
        .ld_ret_addr    (ld_ret_addr),
        .busy           (busy),
        .ld_issue_ready (ld_issue_ready),
        .ret_accept     (ret_accept),
        .pending_cnt    (pending_cnt),
        .sb_err         (sb_err)
    );

    assign wr_ok = wr_en && !(ZERO_REG && (waddr == '0));

    // Data array: the load return is applied last so it wins over an ALU write.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i < DEPTH; i++) regs[i] <= '0;
        end else begin
            if (wr_ok)      regs[waddr]       <= wdata;
            if (ret_accept) regs[ld_ret_addr] <= ld_ret_data;
        end
    end

    // Read port A: array value, optional forwarding, then the zero-register override.
    always_comb begin
        data_outA = regs[raddrA];
        busyA     = busy[raddrA];
`ifdef REGFILE_BYPASS_EN
        if (wr_en && (waddr == raddrA)) data_outA = wdata;
        if (ret_accept && (ld_ret_addr == raddrA)) begin
            data_outA = ld_ret_data;
            busyA     = 1'b0;
        end
`endif
        if (ZERO_REG && (raddrA == '0)) begin
            data_outA = '0;
            busyA     = 1'b0;
        end
    end

    // Read port B: same rules as port A.
    always_comb begin
        data_outB = regs[raddrB];
        busyB     = busy[raddrB];
`ifdef REGFILE_BYPASS_EN
        if (wr_en && (waddr == raddrB)) data_outB = wdata;
        if (ret_accept && (ld_ret_addr == raddrB)) begin
            data_outB = ld_ret_data;
            busyB     = 1'b0;
        end
`endif
        if (ZERO_REG && (raddrB == '0)) begin
            data_outB = '0;
            busyB     = 1'b0;
        end
    end

endmodule
